// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's LSU (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_we;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_req, mem_addr, mem_wdata, mem_we,
      input  mem_ready, mem_rvalid, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_addr, mem_wdata, mem_we,
      output mem_ready, mem_rvalid, mem_rdata, mem_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, byte-enabled 64-bit storage,
// programmable access latency and right-aligned read data with range checking.
module dmem_responder #(
   parameter int unsigned DEPTH     = 512,
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int unsigned LATENCY   = 1
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] SIZE_BYTES = 64'(DEPTH) << 3;
   localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  we_q, we_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        ready_q;
   logic        rvalid_q;

   // Not reset: contents must survive rst.
   logic [63:0] mem [DEPTH];

   logic [63:0]      off;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [2:0]       boff;
   logic             access;
   logic             wr_en;

   assign off      = addr_q - BASE_ADDR;
   assign in_range = off < SIZE_BYTES;
   assign idx      = off[3 +: IDX_W];
   assign boff     = off[2:0];
   assign access   = (state_q == StBusy) && (cnt_q == '0);
   assign wr_en    = access && in_range && (we_q != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.mem_req && ready_q) begin
               state_d = StBusy;
               cnt_d   = CNT_INIT;
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               we_d    = bus.mem_we;
            end
         end
         StBusy: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StResp;
               err_d   = ~in_range;
               // Right-align within the word; bytes past the word boundary read as zero.
               rdata_d = (in_range && (we_q == '0)) ? (mem[idx] >> {boff, 3'b000}) : '0;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         ready_q  <= (state_d == StIdle);
         rvalid_q <= (state_d == StResp);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign bus.mem_ready  = ready_q;
   assign bus.mem_rvalid = rvalid_q;
   assign bus.mem_rdata  = rdata_q;
   assign bus.mem_err    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=1 instance for data/range/reset checks,
// LATENCY=4 instance for request spacing under a continuously held request.
module tb_dmem_responder;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if bus1();
   dmem_responder_if bus4();

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(64'h0), .LATENCY(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(64'h0), .LATENCY(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   typedef struct {
      string       tag;
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Response monitor for the LATENCY=1 instance.
   always @(negedge clk) begin
      if (!rst && bus1.mem_rvalid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_rvalid", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq({mon_e.tag, "_rdata"}, bus1.mem_rdata, mon_e.rdata);
            check_eq({mon_e.tag, "_err"}, 64'(bus1.mem_err), 64'(mon_e.err));
         end
      end
   end

   task automatic txn(input string tag, input logic [63:0] addr, input logic [7:0] we,
                      input logic [63:0] wdata, input logic [63:0] exp_rdata,
                      input logic exp_err);
      int lat;
      int waits;
      exp_q.push_back('{tag, exp_rdata, exp_err});
      @(negedge clk);
      bus1.mem_req   = 1'b1;
      bus1.mem_addr  = addr;
      bus1.mem_we    = we;
      bus1.mem_wdata = wdata;
      waits = 0;
      while (!bus1.mem_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!bus1.mem_ready) begin
         check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
         bus1.mem_req = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      // Inputs are don't-care after acceptance; scramble them.
      bus1.mem_req   = 1'b0;
      bus1.mem_addr  = {$urandom, $urandom};
      bus1.mem_we    = 8'($urandom);
      bus1.mem_wdata = {$urandom, $urandom};
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus1.mem_rvalid && lat < 20);
      check_eq({tag, "_lat"}, 64'(lat), 64'd2);
   endtask

   int acc[$];
   int pulses[$];
   int width;
   int max_width;
   int ready_cnt;
   logic seen;

   initial begin
      rst = 1'b1;
      bus1.mem_req = 1'b0; bus1.mem_addr = '0; bus1.mem_we = '0; bus1.mem_wdata = '0;
      bus4.mem_req = 1'b0; bus4.mem_addr = '0; bus4.mem_we = '0; bus4.mem_wdata = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 64'(bus1.mem_ready), 64'd1);
      check_eq("rst_rvalid", 64'(bus1.mem_rvalid), 64'd0);
      check_eq("rst_rdata", bus1.mem_rdata, 64'd0);
      check_eq("rst_err", 64'(bus1.mem_err), 64'd0);
      check_eq("rst4_ready", 64'(bus4.mem_ready), 64'd1);
      rst = 1'b0;

      txn("sd_10", 64'h10, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0);
      txn("ld_10", 64'h10, 8'h00, 64'h0, 64'h1122334455667788, 1'b0);
      txn("sb_13", 64'h13, 8'h08, 64'hABABABABABABABAB, 64'h0, 1'b0);
      txn("ld_10b", 64'h10, 8'h00, 64'h0, 64'h11223344AB667788, 1'b0);
      txn("ld_13", 64'h13, 8'h00, 64'h0, 64'h00000011223344AB, 1'b0);
      txn("ld_16", 64'h16, 8'h00, 64'h0, 64'h0000000000001122, 1'b0);
      txn("sd_78", 64'h78, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0);
      txn("ld_oor", 64'h80, 8'h00, 64'h0, 64'h0, 1'b1);
      txn("sd_oor", 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b1);
      txn("ld_78", 64'h78, 8'h00, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0);

      // Reset during BUSY aborts the pending write.
      txn("sd_20", 64'h20, 8'hFF, 64'h5555AAAA5555AAAA, 64'h0, 1'b0);
      @(negedge clk);
      bus1.mem_req   = 1'b1;
      bus1.mem_addr  = 64'h20;
      bus1.mem_we    = 8'hFF;
      bus1.mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk);
      #1;
      bus1.mem_req = 1'b0;
      check_eq("abort_busy_ready", 64'(bus1.mem_ready), 64'd0);
      rst = 1'b1;
      #1;
      check_eq("abort_async_ready", 64'(bus1.mem_ready), 64'd1);
      check_eq("abort_async_rvalid", 64'(bus1.mem_rvalid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check_eq("abort_rdata_cleared", bus1.mem_rdata, 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus1.mem_rvalid) seen = 1'b1;
      end
      check_eq("abort_no_rvalid", 64'(seen), 64'd0);
      txn("ld_20_kept", 64'h20, 8'h00, 64'h0, 64'h5555AAAA5555AAAA, 1'b0);
      txn("ld_10_kept", 64'h10, 8'h00, 64'h0, 64'h11223344AB667788, 1'b0);

      // LATENCY=4 with request held high.
      @(negedge clk);
      bus4.mem_req   = 1'b1;
      bus4.mem_addr  = 64'h8;
      bus4.mem_we    = 8'hFF;
      bus4.mem_wdata = 64'h0F0F0F0F0F0F0F0F;
      width = 0; max_width = 0; ready_cnt = 0;
      for (int c = 0; c < 26; c++) begin
         if (bus4.mem_ready) begin
            ready_cnt++;
            acc.push_back(c);
         end
         if (bus4.mem_rvalid) begin
            if (width == 0) pulses.push_back(c);
            width++;
            if (width > max_width) max_width = width;
         end else begin
            width = 0;
         end
         @(negedge clk);
      end
      bus4.mem_req = 1'b0;
      check_eq("l4_accepts", 64'(acc.size()), 64'd5);
      check_eq("l4_ready_cycles", 64'(ready_cnt), 64'd5);
      check_eq("l4_pulses", 64'(pulses.size()), 64'd4);
      check_eq("l4_pulse_width", 64'(max_width), 64'd1);
      for (int i = 1; i < acc.size(); i++) check_eq("l4_spacing", 64'(acc[i] - acc[i-1]), 64'd6);
      if (pulses.size() > 0 && acc.size() > 0)
         check_eq("l4_first_rvalid", 64'(pulses[0] - acc[0]), 64'd5);
      repeat (8) @(negedge clk);

      check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
